// File: rtl/one_hot_seq_pkg.sv
// rtl/one_hot_seq_pkg.sv - shared constants and helpers for the one-hot sequencer
package one_hot_seq_pkg;

    localparam logic DIR_FWD = 1'b0;
    localparam logic DIR_REV = 1'b1;

    localparam int unsigned RESET_IDX  = 0;
    localparam int unsigned MAX_STATES = 32;

    // Callers size-cast the result down to their own state width.
    function automatic logic [MAX_STATES-1:0] idx_to_onehot(input int unsigned idx);
        return {{(MAX_STATES-1){1'b0}}, 1'b1} << idx;
    endfunction

endpackage

// File: rtl/one_hot_seq_fsm_onehot_to_bin.sv
// rtl/one_hot_seq_fsm_onehot_to_bin.sv - one-hot to binary encoder with one-hot validity flag
module onehot_to_bin #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] onehot_i,
    output logic [W-1:0] bin_o,
    output logic         is_onehot_o
);

    always_comb begin
        bin_o = '0;
        for (int i = 0; i < N; i++) begin
            if (onehot_i[i]) begin
                bin_o = bin_o | W'(i);
            end
        end
    end

    assign is_onehot_o = $onehot(onehot_i);

endmodule

// File: rtl/one_hot_seq_fsm.sv
// rtl/one_hot_seq_fsm.sv - one-hot state sequencer with dwell, direction and gating; option ONE_HOT_SEQ_LOAD_EN
module one_hot_seq_fsm
    import one_hot_seq_pkg::*;
#(
    parameter int NUM_STATES = 4,
    parameter int DWELL_W    = 4,
    localparam int IDX_W     = (NUM_STATES > 1) ? $clog2(NUM_STATES) : 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  en,
    input  logic                  hold,
    input  logic                  dir,
    input  logic [DWELL_W-1:0]    dwell,
`ifdef ONE_HOT_SEQ_LOAD_EN
    input  logic                  load,
    input  logic [IDX_W-1:0]      load_idx,
`endif
    output logic [NUM_STATES-1:0] state,
    output logic [IDX_W-1:0]      out,
    output logic                  wrap,
    output logic                  seq_err
);

    localparam logic [NUM_STATES-1:0] RESET_STATE = NUM_STATES'(idx_to_onehot(RESET_IDX));
    localparam logic [IDX_W-1:0]      RESET_OUT   = IDX_W'(RESET_IDX);
    localparam logic [IDX_W-1:0]      LAST_IDX    = IDX_W'(NUM_STATES - 1);
    localparam logic [IDX_W:0]        NUM_S       = (IDX_W + 1)'(NUM_STATES);

    logic [NUM_STATES-1:0] state_q, state_d;
    logic [IDX_W-1:0]      out_q, out_d;
    logic [DWELL_W-1:0]    cnt_q, cnt_d;
    logic                  wrap_q, wrap_d;
    logic                  err_q, err_d;

    logic [IDX_W-1:0]      cur_idx;
    logic                  cur_ok;
    logic [IDX_W-1:0]      step_idx;
    logic                  step_wraps;
    logic                  load_hit;
    logic                  load_bad;
    logic [IDX_W-1:0]      load_tgt;

    onehot_to_bin #(
        .N (NUM_STATES),
        .W (IDX_W)
    ) u_enc (
        .onehot_i    (state_q),
        .bin_o       (cur_idx),
        .is_onehot_o (cur_ok)
    );

`ifdef ONE_HOT_SEQ_LOAD_EN
    assign load_hit = en && load && ({1'b0, load_idx} < NUM_S);
    assign load_bad = en && load && !({1'b0, load_idx} < NUM_S);
    assign load_tgt = load_idx;
`else
    assign load_hit = 1'b0;
    assign load_bad = 1'b0;
    assign load_tgt = RESET_OUT;
`endif

    // dir only matters here, so it is effectively sampled at the advance edge.
    always_comb begin
        if (dir == DIR_REV) begin
            step_wraps = (cur_idx == '0);
            step_idx   = step_wraps ? LAST_IDX : cur_idx - IDX_W'(1);
        end else begin
            step_wraps = (cur_idx == LAST_IDX);
            step_idx   = step_wraps ? '0 : cur_idx + IDX_W'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        cnt_d   = cnt_q;
        wrap_d  = 1'b0;
        err_d   = err_q;
        if (!cur_ok) begin
            state_d = RESET_STATE;
            out_d   = RESET_OUT;
            cnt_d   = '0;
            err_d   = 1'b1;
        end else if (load_hit) begin
            state_d = NUM_STATES'(idx_to_onehot(32'(load_tgt)));
            out_d   = load_tgt;
            cnt_d   = '0;
        end else if (load_bad) begin
            err_d   = 1'b1;
        end else if (en && !hold) begin
            if (cnt_q >= dwell) begin
                state_d = NUM_STATES'(idx_to_onehot(32'(step_idx)));
                out_d   = step_idx;
                cnt_d   = '0;
                wrap_d  = step_wraps;
            end else begin
                cnt_d   = cnt_q + DWELL_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= RESET_STATE;
            out_q   <= RESET_OUT;
            cnt_q   <= '0;
            wrap_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            cnt_q   <= cnt_d;
            wrap_q  <= wrap_d;
            err_q   <= err_d;
        end
    end

    assign state   = state_q;
    assign out     = out_q;
    assign wrap    = wrap_q;
    assign seq_err = err_q;

endmodule

// File: tb/tb_one_hot_seq_fsm.sv
// tb/tb_one_hot_seq_fsm.sv - scoreboard bench for one_hot_seq_fsm; option ONE_HOT_SEQ_LOAD_EN
module tb_one_hot_seq_fsm;

`ifdef ONE_HOT_SEQ_LOAD_EN
    localparam int N = 6;
`else
    localparam int N = 4;
`endif
    localparam int IW = $clog2(N);
    localparam int DW = 4;

    logic          clk = 1'b0;
    logic          reset_n, en, hold, dir;
    logic [DW-1:0] dwell;
    logic [N-1:0]  state;
    logic [IW-1:0] out;
    logic          wrap, seq_err;
`ifdef ONE_HOT_SEQ_LOAD_EN
    logic          load;
    logic [IW-1:0] load_idx;
`endif

    typedef struct {
        logic [N-1:0]  st;
        logic [IW-1:0] ix;
        logic          wr;
        logic          er;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   m_idx, m_cnt;
    logic m_wrap, m_err;
    int   wraps, wrap_at;

    one_hot_seq_fsm #(
        .NUM_STATES (N),
        .DWELL_W    (DW)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .en       (en),
        .hold     (hold),
        .dir      (dir),
        .dwell    (dwell),
`ifdef ONE_HOT_SEQ_LOAD_EN
        .load     (load),
        .load_idx (load_idx),
`endif
        .state    (state),
        .out      (out),
        .wrap     (wrap),
        .seq_err  (seq_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        m_wrap = 1'b0;
        if (!reset_n) begin
            m_idx = 0;
            m_cnt = 0;
            m_err = 1'b0;
        end else if (en) begin
`ifdef ONE_HOT_SEQ_LOAD_EN
            if (load) begin
                if (int'(load_idx) < N) begin
                    m_idx = int'(load_idx);
                    m_cnt = 0;
                end else begin
                    m_err = 1'b1;
                end
            end else
`endif
            if (!hold) begin
                if (m_cnt >= int'(dwell)) begin
                    if (dir) begin
                        m_wrap = (m_idx == 0);
                        m_idx  = (m_idx == 0) ? N - 1 : m_idx - 1;
                    end else begin
                        m_wrap = (m_idx == N - 1);
                        m_idx  = (m_idx + 1) % N;
                    end
                    m_cnt = 0;
                end else begin
                    m_cnt++;
                end
            end
        end
    endtask

    task automatic tick();
        exp_t e;
        model_step();
        e.st = N'(1) << m_idx;
        e.ix = IW'(m_idx);
        e.wr = m_wrap;
        e.er = m_err;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        chk("state", 32'(state), 32'(e.st));
        chk("out", 32'(out), 32'(e.ix));
        chk("wrap", 32'(wrap), 32'(e.wr));
        chk("seq_err", 32'(seq_err), 32'(e.er));
    endtask

    initial begin
        reset_n = 1'b0;
        en      = 1'b0;
        hold    = 1'b0;
        dir     = 1'b0;
        dwell   = '0;
`ifdef ONE_HOT_SEQ_LOAD_EN
        load     = 1'b0;
        load_idx = '0;
`endif
        m_idx = 0; m_cnt = 0; m_wrap = 1'b0; m_err = 1'b0;

        tick();
        tick();
        chk("reset_state", 32'(state), 32'd1);

        reset_n = 1'b1;
        en      = 1'b1;
        wraps   = 0;
        repeat (N + 1) begin
            tick();
            if (wrap === 1'b1) wraps++;
        end
        chk("fwd_wrap_count", 32'(wraps), 32'd1);

        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        dwell   = 4'd2;
        wrap_at = -1;
        for (int c = 1; c <= 3 * N; c++) begin
            tick();
            if (wrap === 1'b1 && wrap_at < 0) wrap_at = c;
        end
        chk("dwell2_wrap_cycle", 32'(wrap_at), 32'(3 * N));

        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        dwell   = '0;
        dir     = 1'b1;
        tick();
        chk("rev_first_wrap", 32'(wrap), 32'd1);
        chk("rev_first_state", 32'(state), 32'(N'(1) << (N - 1)));
        repeat (N - 1) tick();

        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        dir     = 1'b0;
        dwell   = 4'd3;
        repeat (2) tick();
        hold = 1'b1;
        repeat (5) tick();
        hold = 1'b0;
        tick();
        chk("hold_resume_wait", 32'(out), 32'd0);
        tick();
        chk("hold_resume_adv", 32'(out), 32'd1);

        en = 1'b0;
        repeat (3) tick();
        en = 1'b1;

        hold    = 1'b1;
        reset_n = 1'b0;
        tick();
        chk("reset_in_hold", 32'(state), 32'd1);
        reset_n = 1'b1;
        hold    = 1'b0;

        dwell = 4'd7;
        repeat (4) tick();
        dwell = 4'd1;
        tick();
        chk("dwell_drop_adv", 32'(out), 32'd1);

        dwell = 4'd3;
        tick();
        dir = 1'b1;
        repeat (2) tick();
        chk("dir_toggle_hold", 32'(out), 32'd1);
        tick();
        chk("dir_toggle_adv", 32'(out), 32'd0);
        dir = 1'b0;

        repeat (60) begin
            en    = ($urandom_range(0, 3) != 0);
            hold  = ($urandom_range(0, 4) == 0);
            dir   = 1'($urandom_range(0, 1));
            dwell = DW'($urandom_range(0, 3));
            tick();
        end

        en   = 1'b0;
        hold = 1'b0;
        @(negedge clk);
        force dut.state_q = N'(6);
        @(posedge clk);
        #1;
        release dut.state_q;
        @(posedge clk);
        #1;
        m_idx = 0; m_cnt = 0; m_err = 1'b1;
        chk("recover_state", 32'(state), 32'd1);
        chk("recover_out", 32'(out), 32'd0);
        chk("recover_err", 32'(seq_err), 32'd1);
        repeat (2) tick();
        en    = 1'b1;
        dwell = 4'd0;
        repeat (3) tick();

        reset_n = 1'b0;
        tick();
        chk("err_cleared", 32'(seq_err), 32'd0);
        reset_n = 1'b1;

`ifdef ONE_HOT_SEQ_LOAD_EN
        dwell    = 4'd5;
        hold     = 1'b1;
        load     = 1'b1;
        load_idx = IW'(4);
        tick();
        chk("load4_state", 32'(state), 32'h10);
        chk("load4_out", 32'(out), 32'd4);
        load_idx = IW'(7);
        tick();
        chk("load7_state", 32'(state), 32'h10);
        chk("load7_err", 32'(seq_err), 32'd1);
        load = 1'b0;
        hold = 1'b0;
        repeat (8) tick();
        chk("load7_sticky", 32'(seq_err), 32'd1);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
